// File: rtl/pir_sensor_frontend.sv
// rtl/pir_sensor_frontend.sv - three-channel PIR sync, debounce and activity-level integrator
// Optional stuck-high detection is built when PIR_STUCK_DETECT_EN is defined.
module pir_sensor_frontend #(
  parameter int WARMUP_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int RISE_DIV        = 4,
  parameter int FALL_DIV        = 8,
  parameter int HOLD_CYCLES     = 32,
  parameter int LEVEL_MAX       = 100,
  parameter int THRESH          = 50
`ifdef PIR_STUCK_DETECT_EN
  ,
  parameter int STUCK_CYCLES    = 4096
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] pir_raw,
  output logic [6:0] pir_sensor_1,
  output logic [6:0] pir_sensor_2,
  output logic [6:0] pir_sensor_3,
  output logic [2:0] motion_pulse,
  output logic       ready,
  output logic [2:0] fault
);
  localparam int WW   = $clog2(WARMUP_CYCLES + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PDIV = (RISE_DIV > FALL_DIV) ? RISE_DIV : FALL_DIV;
  localparam int PW   = $clog2(PDIV + 1);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] RISE_LAST = PW'(RISE_DIV - 1);
  localparam logic [PW-1:0] FALL_LAST = PW'(FALL_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [6:0]    LVL_MAX   = 7'(LEVEL_MAX);
  localparam logic [6:0]    THR       = 7'(THRESH);

  typedef enum logic {G_WARMUP, G_RUN} gstate_e;
  typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_HOLD, C_DECAY} cstate_e;

  gstate_e         gstate_q, gstate_d;
  logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [2:0]      sync1_q, sync2_q, deb_q, deb_d, above_q, above_d, pulse_q, pulse_d;
  logic [DW-1:0]   deb_cnt_q [3];
  logic [DW-1:0]   deb_cnt_d [3];
  cstate_e         cst_q [3];
  cstate_e         cst_d [3];
  logic [6:0]      lvl_q [3];
  logic [6:0]      lvl_d [3];
  logic [PW-1:0]   pre_q [3];
  logic [PW-1:0]   pre_d [3];
  logic [HW-1:0]   hold_q [3];
  logic [HW-1:0]   hold_d [3];
  logic [2:0]      kill_w, flt_w;
  logic            run;

  assign run = (gstate_q == G_RUN);

  always_comb begin
    gstate_d   = gstate_q;
    warm_cnt_d = warm_cnt_q;
    if (gstate_q == G_WARMUP) begin
      if (warm_cnt_q == WARM_LAST) gstate_d = G_RUN;
      else                         warm_cnt_d = warm_cnt_q + 1'b1;
    end
  end

  // Debouncer runs from reset so inputs are already settled when RUN begins.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = ~deb_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef PIR_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STK_LAST = SW'(STUCK_CYCLES - 1);
  logic [SW-1:0] stuck_cnt_q [3];
  logic [SW-1:0] stuck_cnt_d [3];
  logic [2:0]    fault_q, fault_d, stuck_hit;

  always_comb begin
    fault_d   = fault_q;
    stuck_hit = '0;
    for (int i = 0; i < 3; i++) begin
      stuck_cnt_d[i] = stuck_cnt_q[i];
      stuck_hit[i]   = run && deb_q[i] && !fault_q[i] && (stuck_cnt_q[i] == STK_LAST);
      if (!deb_q[i])                                     stuck_cnt_d[i] = '0;
      else if (run && !fault_q[i] && !stuck_hit[i])      stuck_cnt_d[i] = stuck_cnt_q[i] + 1'b1;
      if (stuck_hit[i]) fault_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      for (int i = 0; i < 3; i++) stuck_cnt_q[i] <= '0;
    end else begin
      fault_q <= fault_d;
      for (int i = 0; i < 3; i++) stuck_cnt_q[i] <= stuck_cnt_d[i];
    end
  end

  assign kill_w = fault_q | stuck_hit;
  assign flt_w  = fault_q;
  assign fault  = fault_q;
`else
  assign kill_w = '0;
  assign flt_w  = '0;
  assign fault  = '0;
`endif

  always_comb begin
    above_d = '0;
    pulse_d = '0;
    for (int i = 0; i < 3; i++) begin
      cst_d[i]  = cst_q[i];
      lvl_d[i]  = lvl_q[i];
      pre_d[i]  = pre_q[i];
      hold_d[i] = hold_q[i];
      above_d[i] = (lvl_q[i] >= THR);
      pulse_d[i] = (lvl_q[i] >= THR) && !above_q[i] && !flt_w[i];
      if (kill_w[i]) begin
        cst_d[i]  = C_IDLE;
        lvl_d[i]  = '0;
        pre_d[i]  = '0;
        hold_d[i] = '0;
      end else if (run) begin
        case (cst_q[i])
          C_IDLE: begin
            lvl_d[i] = '0;
            if (deb_q[i]) begin
              cst_d[i] = C_ACTIVE;
              pre_d[i] = '0;
            end
          end
          C_ACTIVE: begin
            if (!deb_q[i]) begin
              cst_d[i]  = C_HOLD;
              pre_d[i]  = '0;
              hold_d[i] = '0;
            end else if (pre_q[i] == RISE_LAST) begin
              pre_d[i] = '0;
              if (lvl_q[i] < LVL_MAX) lvl_d[i] = lvl_q[i] + 7'd1;
            end else begin
              pre_d[i] = pre_q[i] + 1'b1;
            end
          end
          C_HOLD: begin
            if (deb_q[i]) begin
              cst_d[i] = C_ACTIVE;
              pre_d[i] = '0;
            end else if (hold_q[i] == HOLD_LAST) begin
              cst_d[i] = C_DECAY;
              pre_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
          C_DECAY: begin
            if (deb_q[i]) begin
              cst_d[i] = C_ACTIVE;
              pre_d[i] = '0;
            end else if (lvl_q[i] == 7'd0) begin
              cst_d[i] = C_IDLE;
            end else if (pre_q[i] == FALL_LAST) begin
              pre_d[i] = '0;
              lvl_d[i] = lvl_q[i] - 7'd1;
              if (lvl_q[i] == 7'd1) cst_d[i] = C_IDLE;
            end else begin
              pre_d[i] = pre_q[i] + 1'b1;
            end
          end
          default: cst_d[i] = C_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gstate_q   <= G_WARMUP;
      warm_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      above_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
        cst_q[i]     <= C_IDLE;
        lvl_q[i]     <= '0;
        pre_q[i]     <= '0;
        hold_q[i]    <= '0;
      end
    end else begin
      gstate_q   <= gstate_d;
      warm_cnt_q <= warm_cnt_d;
      sync1_q    <= pir_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      above_q    <= above_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        cst_q[i]     <= cst_d[i];
        lvl_q[i]     <= lvl_d[i];
        pre_q[i]     <= pre_d[i];
        hold_q[i]    <= hold_d[i];
      end
    end
  end

  assign pir_sensor_1 = lvl_q[0];
  assign pir_sensor_2 = lvl_q[1];
  assign pir_sensor_3 = lvl_q[2];
  assign motion_pulse = pulse_q;
  assign ready        = run;
endmodule

// File: tb/tb_pir_sensor_frontend.sv
// tb/tb_pir_sensor_frontend.sv - directed/random bench for pir_sensor_frontend with a rule-level reference model
// Stuck-detect checks are included when PIR_STUCK_DETECT_EN is defined.
module tb_pir_sensor_frontend;
  localparam int W = 16, D = 4, R = 2, F = 4, H = 8, LMAX = 100, T = 50;
`ifdef PIR_STUCK_DETECT_EN
  localparam int S = 256;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pir_raw;
  logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
  logic [2:0] motion_pulse, fault;
  logic       ready;

  always #5 clk = ~clk;

  pir_sensor_frontend #(
    .WARMUP_CYCLES(W), .DEBOUNCE_CYCLES(D), .RISE_DIV(R), .FALL_DIV(F),
    .HOLD_CYCLES(H), .LEVEL_MAX(LMAX), .THRESH(T)
`ifdef PIR_STUCK_DETECT_EN
    , .STUCK_CYCLES(S)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .pir_raw(pir_raw),
    .pir_sensor_1(pir_sensor_1), .pir_sensor_2(pir_sensor_2), .pir_sensor_3(pir_sensor_3),
    .motion_pulse(motion_pulse), .ready(ready), .fault(fault)
  );

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;

  // Reference model: phase 0 idle, 1 rising, 2 holding, 3 decaying.
  // Level is a closed-form function of cycles spent in the phase and the level on entry.
  int         cyc = 0;
  bit [D+1:0] hist [3];
  bit         m_deb [3];
  int         ph [3];
  int         lvl [3];
  int         base [3];
  int         n [3];
  bit         above [3];
  bit         pulse [3];
  bit         mfault [3];
  bit         m_run, m_hit;
`ifdef PIR_STUCK_DETECT_EN
  int         sc [3];
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
        hist[i] = '0; m_deb[i] = 0; ph[i] = 0; lvl[i] = 0; base[i] = 0; n[i] = 0;
        above[i] = 0; pulse[i] = 0; mfault[i] = 0;
`ifdef PIR_STUCK_DETECT_EN
        sc[i] = 0;
`endif
      end
    end else begin
      m_run = (cyc >= W);
      if (cyc < W) cyc++;
      for (int i = 0; i < 3; i++) begin
        m_hit = 0;
`ifdef PIR_STUCK_DETECT_EN
        if (!m_deb[i]) sc[i] = 0;
        else if (m_run && !mfault[i]) begin
          sc[i]++;
          if (sc[i] == S) m_hit = 1;
        end
`endif
        pulse[i] = (lvl[i] >= T) && !above[i] && !mfault[i];
        above[i] = (lvl[i] >= T);
        if (mfault[i] || m_hit) begin
          ph[i] = 0; lvl[i] = 0;
        end else if (m_run) begin
          case (ph[i])
            0: begin
              lvl[i] = 0;
              if (m_deb[i]) begin ph[i] = 1; base[i] = lvl[i]; n[i] = 0; end
            end
            1: begin
              if (!m_deb[i]) begin ph[i] = 2; n[i] = 0; end
              else begin
                n[i]++;
                lvl[i] = (base[i] + n[i] / R > LMAX) ? LMAX : base[i] + n[i] / R;
              end
            end
            2: begin
              if (m_deb[i]) begin ph[i] = 1; base[i] = lvl[i]; n[i] = 0; end
              else begin
                n[i]++;
                if (n[i] == H) begin ph[i] = 3; base[i] = lvl[i]; n[i] = 0; end
              end
            end
            default: begin
              if (m_deb[i]) begin ph[i] = 1; base[i] = lvl[i]; n[i] = 0; end
              else if (lvl[i] == 0) ph[i] = 0;
              else begin
                n[i]++;
                lvl[i] = base[i] - n[i] / F;
                if (lvl[i] == 0) ph[i] = 0;
              end
            end
          endcase
        end
        if (m_hit) mfault[i] = 1;
        // Debounced value flips once the last D synchronised samples all disagree with it.
        hist[i] = {hist[i][D:0], pir_raw[i]};
        if (hist[i][D+1:2] == {D{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_fault();
`ifdef PIR_STUCK_DETECT_EN
    return {mfault[2], mfault[1], mfault[0]};
`else
    return 3'b000;
`endif
  endfunction

  task automatic check_outputs();
    chk("pir_sensor_1", pir_sensor_1, lvl[0]);
    chk("pir_sensor_2", pir_sensor_2, lvl[1]);
    chk("pir_sensor_3", pir_sensor_3, lvl[2]);
    chk("motion_pulse", motion_pulse, {pulse[2], pulse[1], pulse[0]});
    chk("ready", ready, (cyc >= W));
    chk("fault", fault, exp_fault());
    pulses0 += int'(motion_pulse[0]);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    int k;
    rst_n   = 1'b0;
    pir_raw = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_lvl1", pir_sensor_1, 0);
    chk("reset_ready", ready, 0);
    chk("reset_pulse", motion_pulse, 0);
    chk("reset_fault", fault, 0);
    rst_n = 1'b1;

    // Warm-up with all inputs high
    step(W - 1);
    chk("warmup_ready_low", ready, 0);
    chk("warmup_lvl3_zero", pir_sensor_3, 0);
    step(1);
    chk("warmup_ready_high", ready, 1);
    step(4);
    pir_raw = 3'b000;
    step(200);
    chk("settle_lvl1", pir_sensor_1, 0);
    chk("settle_lvl2", pir_sensor_2, 0);

    // Short glitches on channel 1 never pass the debouncer
    for (int g = 0; g < 3; g++) begin
      pir_raw[1] = 1'b1;
      step($urandom_range(1, D - 1));
      pir_raw[1] = 1'b0;
      step(30);
      chk("glitch_lvl2", pir_sensor_2, 0);
    end

    // Channel 0 rise to saturation with a single threshold pulse
    pulses0 = 0;
    pir_raw = 3'b001;
    step(240);
    chk("rise_sat_lvl1", pir_sensor_1, 100);
    chk("rise_other_lvl2", pir_sensor_2, 0);
    chk("rise_other_lvl3", pir_sensor_3, 0);
    chk("rise_pulse_count", pulses0, 1);

    // Fall, hold, re-trigger during hold, then full decay
    pir_raw = 3'b000;
    step(2 + D + 4);
    chk("hold_lvl1", pir_sensor_1, 100);
    pir_raw = 3'b001;
    step(12);
    chk("retrigger_lvl1", pir_sensor_1, 100);
    pir_raw = 3'b000;
    step(2 + D + H + 400 + 20);
    chk("decay_lvl1", pir_sensor_1, 0);

    // Random activity bursts separated by debounced quiet gaps
    for (int b = 0; b < 20; b++) begin
      pir_raw = 3'($urandom_range(0, 7));
      step($urandom_range(1, 40));
      pir_raw = 3'b000;
      step($urandom_range(D + 2, 20));
    end
    step(20);

    // Asynchronous reset with channel 2 active
    pir_raw = 3'b100;
    k = 0;
    while (lvl[2] < 60 && k < 400) begin
      step(1);
      k++;
    end
    chk("ch2_reached_60", (pir_sensor_3 >= 7'd60), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lvl3", pir_sensor_3, 0);
    chk("async_rst_ready", ready, 0);
    chk("async_rst_pulse", motion_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(W - 1);
    chk("rewarm_ready_low", ready, 0);
    step(1);
    chk("rewarm_ready_high", ready, 1);

`ifdef PIR_STUCK_DETECT_EN
    step(2 + D + S + 10);
    chk("stuck_fault2", fault[2], 1);
    chk("stuck_lvl3", pir_sensor_3, 0);
    step(50);
    chk("stuck_lvl3_stays", pir_sensor_3, 0);
`else
    step(30);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
